tcam_search_ctrl: RTL and testbench
===================================

TCAM_SEARCH_CTRL -- requirements
Module: tcam_search_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 10, key/entry width in bits.
REQ-002 SHALL have parameter LANES, default 4, entries compared per scan cycle; legal values 1, 2, 4, 8, 16.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-low (low = reset asserted).
REQ-005 SHALL have port upd_valid  input  1  update request.
REQ-006 SHALL have port upd_ready  output  1  update accepted when upd_valid and upd_ready are both high on a clock edge.
REQ-007 SHALL have port upd_op  input  1  0 = write entry, 1 = invalidate entry.
REQ-008 SHALL have port upd_addr  input  4  target entry index 0-15.
REQ-009 SHALL have port upd_value  input  DATA_W  entry value.
REQ-010 SHALL have port upd_mask  input  DATA_W  don't-care mask; bit = 1 ignores that key bit.
REQ-011 SHALL have port srch_valid  input  1  search request.
REQ-012 SHALL have port srch_ready  output  1  search accepted when srch_valid and srch_ready are both high on a clock edge.
REQ-013 SHALL have port srch_key  input  DATA_W  search key; sampled at acceptance.
REQ-014 SHALL have port rsp_valid  output  1  search result valid.
REQ-015 SHALL have port rsp_ready  input  1  result consumed when rsp_valid and rsp_ready are both high.
REQ-016 SHALL have port rsp_hit  output  1  1 = at least one entry matched.
REQ-017 SHALL have port rsp_index  output  4  lowest matching index; 0 on miss.
REQ-018 SHALL have port rsp_seg0  output  7  units digit of rsp_index, segments a..g MSB-first, active-high.
REQ-019 SHALL have port rsp_seg1  output  7  tens digit of rsp_index, same encoding.

Function
REQ-020 SHALL hold 16 entries, each {valid, value[DATA_W], mask[DATA_W]}.
REQ-021 Entry i SHALL match when valid_i and ((value_i XOR key) AND NOT mask_i) == 0.
REQ-022 FSM states SHALL be IDLE, SCAN, RESP; upd_ready and srch_ready SHALL be low outside IDLE.
REQ-023 In IDLE, a round-robin pointer (reset value UPD) SHALL arbitrate: upd_ready = !(srch_valid && ptr==SRCH); srch_ready = !(upd_valid && ptr==UPD).
REQ-024 On each acceptance, the pointer SHALL move to the other requester; with only one requester valid, that requester SHALL be granted every cycle.
REQ-025 An accepted update SHALL take effect at the acceptance edge; the FSM SHALL stay in IDLE; a search accepted on the next cycle SHALL see the new contents.
REQ-026 Write SHALL set valid=1 and store value/mask; invalidate SHALL clear valid only.
REQ-027 An accepted search SHALL latch srch_key and enter SCAN with group counter g=0.
REQ-028 Each SCAN cycle SHALL compare entries g*LANES .. g*LANES+LANES-1.
REQ-029 SCAN SHALL exit to RESP on the first group containing a match, recording the lowest matching index in that group; otherwise it SHALL increment g.
REQ-030 After group 16/LANES-1 with no match, SCAN SHALL enter RESP with rsp_hit=0.
REQ-031 rsp_valid SHALL be high exactly in RESP; rsp_hit, rsp_index and segments SHALL be stable there.
REQ-032 Latency: rsp_valid SHALL rise (g_hit+1) cycles after the acceptance edge on a hit and 16/LANES cycles after it on a miss.
REQ-033 RESP SHALL go to IDLE on the edge where rsp_ready=1; with rsp_ready held high, a new request SHALL be acceptable the cycle after.
REQ-034 Segment encoding SHALL be: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
REQ-035 Index 0-9 SHALL give seg1 = digit 0 and seg0 = digit index; index 10-15 SHALL give seg1 = digit 1 and seg0 = digit (index-10).
REQ-036 On a miss, both seg0 and seg1 SHALL be 0000001 (dash).
REQ-037 Requests arriving outside IDLE SHALL be held by the requester; the block SHALL NOT drop or reorder them.

Reset
REQ-038 While reset is low at an edge: all entries SHALL be cleared to 0 with valid=0, FSM=IDLE, g=0, ptr=UPD, rsp_valid=0, rsp_hit=0, rsp_index=0, rsp_seg0=rsp_seg1=0000000.
REQ-039 Reset during SCAN or RESP SHALL abandon the search with no response produced.

Verification
REQ-040 Write entry 5 with value=0x2A5, mask=0; search key 0x2A5 with LANES=4 -> rsp_valid 2 cycles after acceptance, hit=1, index=5, seg1=1111110, seg0=1011011.
REQ-041 Write entries 3 and 12 with value=0x000, mask=0x3FF; search any key -> index=3 (lowest index wins).
REQ-042 Write entry 14 with value=0x155, mask=0x00F; search key 0x15A -> hit, index=14, seg1=0110000, seg0=0110011; search key 0x055 -> miss, 4-cycle latency, both segments = 0000001.
REQ-043 Hold upd_valid and srch_valid high for 6 cycles from reset -> grants alternate UPD, SRCH, UPD; upd_ready stays low for the whole search duration.
REQ-044 Invalidate entry 5 after REQ-040, then search 0x2A5 -> miss; hold rsp_ready=0 for 3 cycles -> rsp_valid and outputs stay stable, then return to IDLE on rsp_ready=1.
REQ-045 Drive reset low during SCAN -> no rsp_valid afterwards and a following search of 0x2A5 misses.

Source files
------------

// File: rtl/tcam_search_ctrl.sv
// 16-entry ternary CAM with a round-robin update/search front end and a
// multi-cycle lane-parallel scan. The lowest matching index is reported in binary and as two 7-segment digits.
module tcam_search_ctrl #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned LANES  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              upd_valid,
    output logic              upd_ready,
    input  logic              upd_op,
    input  logic [3:0]        upd_addr,
    input  logic [DATA_W-1:0] upd_value,
    input  logic [DATA_W-1:0] upd_mask,
    input  logic              srch_valid,
    output logic              srch_ready,
    input  logic [DATA_W-1:0] srch_key,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_hit,
    output logic [3:0]        rsp_index,
    output logic [6:0]        rsp_seg0,
    output logic [6:0]        rsp_seg1
);

    localparam int unsigned NumEntries = 16;
    localparam int unsigned NumGroups  = NumEntries / LANES;
    localparam logic        PtrUpd     = 1'b0;
    localparam logic        PtrSrch    = 1'b1;
    localparam logic [6:0]  SegDash    = 7'b0000001;

    typedef enum logic [1:0] {StIdle, StScan, StResp} state_e;

    state_e                  state_q, state_d;
    logic                    ptr_q, ptr_d;
    logic [NumEntries-1:0]   valid_q, valid_d;
    logic [DATA_W-1:0]       value_q [NumEntries];
    logic [DATA_W-1:0]       value_d [NumEntries];
    logic [DATA_W-1:0]       mask_q  [NumEntries];
    logic [DATA_W-1:0]       mask_d  [NumEntries];
    logic [DATA_W-1:0]       key_q, key_d;
    logic [3:0]              grp_q, grp_d;
    logic                    hit_q, hit_d;
    logic [3:0]              index_q, index_d;
    logic [6:0]              seg0_q, seg0_d;
    logic [6:0]              seg1_q, seg1_d;

    logic                    grp_hit;
    logic [3:0]              grp_idx;
    logic [3:0]              lane_idx;

    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Walk lanes from high to low so the lowest matching index is the one left standing.
    always_comb begin
        grp_hit  = 1'b0;
        grp_idx  = '0;
        lane_idx = '0;
        for (int l = int'(LANES) - 1; l >= 0; l--) begin
            lane_idx = 4'(int'(grp_q) * int'(LANES) + l);
            if (valid_q[lane_idx] &&
                (((value_q[lane_idx] ^ key_q) & ~mask_q[lane_idx]) == '0)) begin
                grp_hit = 1'b1;
                grp_idx = lane_idx;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        valid_d    = valid_q;
        value_d    = value_q;
        mask_d     = mask_q;
        key_d      = key_q;
        grp_d      = grp_q;
        hit_d      = hit_q;
        index_d    = index_q;
        seg0_d     = seg0_q;
        seg1_d     = seg1_q;
        upd_ready  = 1'b0;
        srch_ready = 1'b0;
        unique case (state_q)
            StIdle: begin
                upd_ready  = !(srch_valid && ptr_q == PtrSrch);
                srch_ready = !(upd_valid && ptr_q == PtrUpd);
                // The two readies are never both granted to a pair of valid requests.
                if (upd_valid && upd_ready) begin
                    ptr_d = PtrSrch;
                    if (upd_op) begin
                        valid_d[upd_addr] = 1'b0;
                    end else begin
                        valid_d[upd_addr] = 1'b1;
                        value_d[upd_addr] = upd_value;
                        mask_d[upd_addr]  = upd_mask;
                    end
                end else if (srch_valid && srch_ready) begin
                    ptr_d   = PtrUpd;
                    key_d   = srch_key;
                    grp_d   = '0;
                    state_d = StScan;
                end
            end
            StScan: begin
                if (grp_hit) begin
                    state_d = StResp;
                    hit_d   = 1'b1;
                    index_d = grp_idx;
                    if (grp_idx < 4'd10) begin
                        seg1_d = seg_digit(4'd0);
                        seg0_d = seg_digit(grp_idx);
                    end else begin
                        seg1_d = seg_digit(4'd1);
                        seg0_d = seg_digit(grp_idx - 4'd10);
                    end
                end else if (grp_q == 4'(NumGroups - 1)) begin
                    state_d = StResp;
                    hit_d   = 1'b0;
                    index_d = '0;
                    seg1_d  = SegDash;
                    seg0_d  = SegDash;
                end else begin
                    grp_d = grp_q + 4'd1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            ptr_q   <= PtrUpd;
            valid_q <= '0;
            value_q <= '{default: '0};
            mask_q  <= '{default: '0};
            key_q   <= '0;
            grp_q   <= '0;
            hit_q   <= 1'b0;
            index_q <= '0;
            seg0_q  <= '0;
            seg1_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            value_q <= value_d;
            mask_q  <= mask_d;
            key_q   <= key_d;
            grp_q   <= grp_d;
            hit_q   <= hit_d;
            index_q <= index_d;
            seg0_q  <= seg0_d;
            seg1_q  <= seg1_d;
        end
    end

    assign rsp_valid = (state_q == StResp);
    assign rsp_hit   = hit_q;
    assign rsp_index = index_q;
    assign rsp_seg0  = seg0_q;
    assign rsp_seg1  = seg1_q;

endmodule

// File: tb/tb_tcam_search_ctrl.sv
// Directed bench for tcam_search_ctrl: update/search vectors with hand-derived
// hits, indices, latencies and segment patterns.
module tb_tcam_search_ctrl;

    localparam logic [6:0] S0 = 7'b1111110;
    localparam logic [6:0] S1 = 7'b0110000;
    localparam logic [6:0] S2 = 7'b1101101;
    localparam logic [6:0] S3 = 7'b1111001;
    localparam logic [6:0] S4 = 7'b0110011;
    localparam logic [6:0] S5 = 7'b1011011;
    localparam logic [6:0] SD = 7'b0000001;

    logic       clk = 1'b0;
    logic       reset;
    logic       upd_valid, upd_ready, upd_op;
    logic [3:0] upd_addr;
    logic [9:0] upd_value, upd_mask;
    logic       srch_valid, srch_ready;
    logic [9:0] srch_key;
    logic       rsp_valid, rsp_ready, rsp_hit;
    logic [3:0] rsp_index;
    logic [6:0] rsp_seg0, rsp_seg1;

    int n_chk  = 0;
    int n_pass = 0;

    tcam_search_ctrl #(.DATA_W(10), .LANES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_op     (upd_op),
        .upd_addr   (upd_addr),
        .upd_value  (upd_value),
        .upd_mask   (upd_mask),
        .srch_valid (srch_valid),
        .srch_ready (srch_ready),
        .srch_key   (srch_key),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_hit    (rsp_hit),
        .rsp_index  (rsp_index),
        .rsp_seg0   (rsp_seg0),
        .rsp_seg1   (rsp_seg1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic upd(input logic op, input logic [3:0] addr, input logic [9:0] val,
                       input logic [9:0] msk);
        int waited = 0;
        @(negedge clk);
        upd_valid = 1'b1; upd_op = op; upd_addr = addr; upd_value = val; upd_mask = msk;
        #1;
        while (!upd_ready && waited < 50) begin
            @(negedge clk); #1; waited++;
        end
        chk("upd_grant", 32'(upd_ready), 1);
        @(posedge clk);
        #1 upd_valid = 1'b0;
    endtask

    // Returns at #1 after the edge where rsp_valid rose.
    task automatic search(input string tag, input logic [9:0] key, input logic exp_hit,
                          input int exp_idx, input int exp_lat, input logic [6:0] e1,
                          input logic [6:0] e0);
        int waited = 0;
        int lat    = 0;
        @(negedge clk);
        srch_valid = 1'b1; srch_key = key;
        #1;
        while (!srch_ready && waited < 50) begin
            @(negedge clk); #1; waited++;
        end
        chk({tag, "_grant"}, 32'(srch_ready), 1);
        @(posedge clk);
        #1;
        srch_valid = 1'b0;
        srch_key   = ~key;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_hit"}, 32'(rsp_hit), 32'(exp_hit));
        chk({tag, "_idx"}, 32'(rsp_index), 32'(exp_idx));
        chk({tag, "_seg1"}, 32'(rsp_seg1), 32'(e1));
        chk({tag, "_seg0"}, 32'(rsp_seg0), 32'(e0));
    endtask

    initial begin
        logic [5:0] exp_u;
        logic [5:0] exp_s;
        upd_valid = 0; upd_op = 0; upd_addr = 0; upd_value = 0; upd_mask = 0;
        srch_valid = 0; srch_key = 0; rsp_ready = 1;
        do_reset();

        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_hit", 32'(rsp_hit), 0);
        chk("rst_idx", 32'(rsp_index), 0);
        chk("rst_seg0", 32'(rsp_seg0), 0);
        chk("rst_seg1", 32'(rsp_seg1), 0);
        chk("rst_upd_rdy", 32'(upd_ready), 1);
        chk("rst_srch_rdy", 32'(srch_ready), 1);

        // Exact match in group 1.
        upd(1'b0, 4'd5, 10'h2A5, 10'h000);
        search("e5", 10'h2A5, 1'b1, 5, 2, S0, S5);

        // Two full wildcards: the lowest index wins; then the next ones surface.
        upd(1'b0, 4'd3, 10'h000, 10'h3FF);
        upd(1'b0, 4'd12, 10'h000, 10'h3FF);
        search("wild3", 10'h123, 1'b1, 3, 1, S0, S3);
        upd(1'b1, 4'd3, 10'h000, 10'h000);
        search("after_inv3", 10'h2A5, 1'b1, 5, 2, S0, S5);
        search("wild12", 10'h001, 1'b1, 12, 4, S1, S2);
        upd(1'b1, 4'd12, 10'h000, 10'h000);

        // Partial mask on entry 14.
        upd(1'b0, 4'd14, 10'h155, 10'h00F);
        search("e14_hit", 10'h15A, 1'b1, 14, 4, S1, S4);
        search("e14_miss", 10'h055, 1'b0, 0, 4, SD, SD);

        // Invalidate 5, then hold the response back for three cycles.
        upd(1'b1, 4'd5, 10'h000, 10'h000);
        rsp_ready = 1'b0;
        search("inv5", 10'h2A5, 1'b0, 0, 4, SD, SD);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(rsp_valid), 1);
            chk("hold_seg0", 32'(rsp_seg0), 32'(SD));
            chk("hold_srch_rdy", 32'(srch_ready), 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_valid", 32'(rsp_valid), 0);
        chk("release_srch_rdy", 32'(srch_ready), 1);

        // Both requesters held high: UPD, SRCH, (search busy), UPD, SRCH.
        do_reset();
        @(negedge clk);
        upd_valid = 1'b1; upd_op = 1'b0; upd_addr = 4'd0; upd_value = 10'h000;
        upd_mask = 10'h000; srch_valid = 1'b1; srch_key = 10'h000;
        exp_u = 6'b010001;
        exp_s = 6'b100010;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("arb_upd_c%0d", c), 32'(upd_ready), 32'(exp_u[c]));
            chk($sformatf("arb_srch_c%0d", c), 32'(srch_ready), 32'(exp_s[c]));
            if (c == 3) begin
                chk("arb_rsp_valid", 32'(rsp_valid), 1);
                chk("arb_rsp_hit", 32'(rsp_hit), 1);
                chk("arb_rsp_idx", 32'(rsp_index), 0);
            end
            @(negedge clk);
        end
        upd_valid = 1'b0; srch_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("arb_drain_valid", 32'(rsp_valid), 0);
        chk("arb_drain_rdy", 32'(srch_ready), 1);

        // Reset in the middle of a scan abandons the search and clears the table.
        upd(1'b0, 4'd5, 10'h2A5, 10'h000);
        @(negedge clk);
        srch_valid = 1'b1; srch_key = 10'h2A5;
        #1;
        chk("rs_grant", 32'(srch_ready), 1);
        @(posedge clk);
        #1;
        srch_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        chk("rs_srch_rdy", 32'(srch_ready), 1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("rs_no_rsp", 32'(rsp_valid), 0);
        end
        chk("rs_seg0", 32'(rsp_seg0), 0);
        search("rs_miss", 10'h2A5, 1'b0, 0, 4, SD, SD);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
